// File: rtl/bsg_fsb_client_out_arbiter.sv
// Round-robin arbiter that funnels several FSB client output channels into one,
// buffering the granted packet with its source tag in a 2-entry queue.

module bsg_fsb_client_out_arbiter_chk #(
    parameter int nodes_p = 2
) (
    input logic               clk_i,
    input logic               reset_i,
    input logic               yumi_i,
    input logic               v_o,
    input logic [nodes_p-1:0] yumi_o
);

    // Downstream may only consume a valid head entry
    yumi_needs_valid_a: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o);

    // At most one upstream node is consumed per cycle
    yumi_onehot_a: assert property (@(posedge clk_i) disable iff (reset_i) $onehot0(yumi_o));

endmodule

module bsg_fsb_client_out_arbiter #(
    parameter int nodes_p     = 2,
    parameter int width_p     = 80,
    parameter int tag_width_p = (nodes_p > 1) ? $clog2(nodes_p) : 1
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [nodes_p-1:0]         en_i,
    input  logic [nodes_p-1:0]         v_i,
    input  logic [nodes_p*width_p-1:0] data_i,
    output logic [nodes_p-1:0]         yumi_o,
    output logic                       v_o,
    output logic [width_p-1:0]         data_o,
    output logic [tag_width_p-1:0]     tag_o,
    input  logic                       yumi_i
);

    logic [1:0]             count_r;
    logic [1:0]             count_next_s;
    logic                   rd_r;
    logic                   wr_r;
    logic                   v_r;
    logic [tag_width_p-1:0] ptr_r;
    logic [tag_width_p-1:0] ptr_next_s;
    logic [tag_width_p-1:0] winner_s;
    logic [width_p-1:0]     sel_data_s;
    logic [tag_width_p-1:0] tag_mem_r  [2];
    logic [width_p-1:0]     data_mem_r [2];
    logic [nodes_p-1:0]     elig_s;
    logic [nodes_p-1:0]     yumi_s;
    logic                   found_s;
    logic                   space_s;
    logic                   enq_s;
    logic                   deq_s;

    assign elig_s  = v_i & en_i;
    assign space_s = (count_r != 2'd2);
    // Grant never depends on yumi_i; reset suppresses handshakes immediately
    assign enq_s   = space_s & found_s & ~reset_i;
    assign deq_s   = yumi_i & (count_r != 2'd0);

    // Pick the eligible node closest to ptr in wrap-around order
    always_comb begin : scan_b
        int best_d;
        int d;
        best_d     = nodes_p;
        d          = 0;
        found_s    = 1'b0;
        winner_s   = {tag_width_p{1'b0}};
        sel_data_s = {width_p{1'b0}};
        ptr_next_s = ptr_r;
        for (int k = 0; k < nodes_p; k++) begin
            d = (k + nodes_p - int'(ptr_r)) % nodes_p;
            if (elig_s[k] && (d < best_d)) begin
                best_d     = d;
                found_s    = 1'b1;
                winner_s   = tag_width_p'(k);
                sel_data_s = data_i[k*width_p +: width_p];
                ptr_next_s = tag_width_p'((k + 1) % nodes_p);
            end else begin
                best_d = best_d;
            end
        end
    end

    // One-hot consume strobe toward the winning node
    always_comb begin
        yumi_s = {nodes_p{1'b0}};
        for (int k = 0; k < nodes_p; k++) begin
            if (enq_s && (int'(winner_s) == k)) begin
                yumi_s[k] = 1'b1;
            end else begin
                yumi_s[k] = 1'b0;
            end
        end
    end

    // Occupancy update; a full queue blocks enqueue even while draining
    always_comb begin
        case ({enq_s, deq_s})
            2'b10:   count_next_s = count_r + 2'd1;
            2'b01:   count_next_s = count_r - 2'd1;
            default: count_next_s = count_r;
        endcase
    end

    // Queue storage, pointers and round-robin state
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_r       <= 2'd0;
            rd_r          <= 1'b0;
            wr_r          <= 1'b0;
            v_r           <= 1'b0;
            ptr_r         <= {tag_width_p{1'b0}};
            tag_mem_r[0]  <= {tag_width_p{1'b0}};
            tag_mem_r[1]  <= {tag_width_p{1'b0}};
            data_mem_r[0] <= {width_p{1'b0}};
            data_mem_r[1] <= {width_p{1'b0}};
        end else begin
            if (enq_s) begin
                tag_mem_r[wr_r]  <= winner_s;
                data_mem_r[wr_r] <= sel_data_s;
                wr_r             <= ~wr_r;
                ptr_r            <= ptr_next_s;
            end
            if (deq_s) begin
                rd_r <= ~rd_r;
            end
            count_r <= count_next_s;
            v_r     <= (count_next_s != 2'd0);
        end
    end

    assign yumi_o = yumi_s;
    assign v_o    = v_r;
    assign data_o = data_mem_r[rd_r];
    assign tag_o  = tag_mem_r[rd_r];

    bsg_fsb_client_out_arbiter_chk #(.nodes_p(nodes_p)) chk (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .yumi_i (yumi_i),
        .v_o    (v_o),
        .yumi_o (yumi_o)
    );

endmodule

// File: tb/tb_bsg_fsb_client_out_arbiter.sv
// Randomized bench for the FSB client output arbiter against a queue-based model.

module tb_bsg_fsb_client_out_arbiter;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int TW = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   en;
    logic [N-1:0]   v;
    logic [N*W-1:0] data;
    logic [N-1:0]   yumi_o;
    logic           v_o;
    logic [W-1:0]   data_o;
    logic [TW-1:0]  tag_o;
    logic           yumi_i;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [W-1:0]  data;
    } ent_t;

    ent_t         q[$];
    int           mptr = 0;
    logic [W-1:0] pkt [N];
    logic [N-1:0] exp_yumi;
    int           exp_win;
    logic [W-1:0] exp_pkt;

    bsg_fsb_client_out_arbiter #(.nodes_p(N), .width_p(W), .tag_width_p(TW)) dut (
        .clk_i  (clk),
        .reset_i(reset),
        .en_i   (en),
        .v_i    (v),
        .data_i (data),
        .yumi_o (yumi_o),
        .v_o    (v_o),
        .data_o (data_o),
        .tag_o  (tag_o),
        .yumi_i (yumi_i)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [N-1:0] en_v, input logic [N-1:0] v_v, input bit yreq, input bit rand_data);
        en = en_v;
        v  = v_v;
        for (int k = 0; k < N; k++) begin
            pkt[k] = rand_data ? W'($urandom) : W'(k);
            data[k*W +: W] = pkt[k];
        end
        yumi_i = yreq && (q.size() > 0);
    endtask

    task automatic calc_expect();
        logic [TW-1:0] kk;
        exp_yumi = '0;
        exp_win  = -1;
        exp_pkt  = '0;
        if (!reset && q.size() < 2) begin
            for (int i = 0; i < N; i++) begin
                kk = TW'((mptr + i) % N);
                if (exp_win < 0 && v[kk] && en[kk]) begin
                    exp_win  = int'(kk);
                    exp_pkt  = pkt[kk];
                    exp_yumi[kk] = 1'b1;
                end
            end
        end
    endtask

    task automatic model_update();
        ent_t e;
        if (reset) begin
            q.delete();
            mptr = 0;
        end else begin
            if (yumi_i && q.size() > 0) void'(q.pop_front());
            if (exp_win >= 0) begin
                e.tag  = TW'(exp_win);
                e.data = exp_pkt;
                q.push_back(e);
                mptr = (exp_win + 1) % N;
            end
        end
    endtask

    task automatic settle();
        @(negedge clk);
        calc_expect();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(4'h0, 4'h0, 1'b0, 1'b1);
        settle();
        tick();
        reset = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) begin
            if (q.size() > 0) begin
                drive(4'h0, 4'h0, 1'b1, 1'b1);
                settle();
                tick();
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(4'hF, 4'hF, 1'b0, 1'b1);
        settle();
        checks++;
        if (yumi_o !== 4'h0 || v_o !== 1'b0 || data_o !== 16'h0 || tag_o !== 2'd0) begin
            errors++;
            $display("FAIL reset_idle yumi_o=%b v_o=%b data_o=%h tag_o=%0d required 0000/0/0000/0", yumi_o, v_o, data_o, tag_o);
        end
        tick();
        reset = 1'b0;
        for (int c = 0; c < 2; c++) begin
            drive(4'h1, 4'h1, 1'b0, 1'b1);
            settle();
            tick();
        end
        drive(4'hF, 4'hF, 1'b0, 1'b1);
        settle();
        checks++;
        if (v_o !== 1'b1 || yumi_o !== 4'h0) begin
            errors++;
            $display("FAIL full_before_reset v_o=%b yumi_o=%b required 1/0000", v_o, yumi_o);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (v_o !== 1'b0 || yumi_o !== 4'h0 || data_o !== 16'h0 || tag_o !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid_cycle v_o=%b yumi_o=%b data_o=%h tag_o=%0d required 0/0000/0000/0", v_o, yumi_o, data_o, tag_o);
        end
        tick();
        reset = 1'b0;
        drive(4'hF, 4'hF, 1'b0, 1'b1);
        settle();
        checks++;
        if (yumi_o !== 4'b0001 || v_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_ptr yumi_o=%b v_o=%b required 0001/0", yumi_o, v_o);
        end
        tick();
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_rr;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            drive(4'hF, 4'hF, 1'b1, 1'b0);
            settle();
            exp_rr = 4'b0001 << (c % 4);
            checks++;
            if (yumi_o !== exp_rr) begin
                errors++;
                $display("FAIL rr_grant cycle %0d yumi_o=%b required %b", c, yumi_o, exp_rr);
            end
            if (c >= 1) begin
                checks++;
                if (v_o !== 1'b1 || int'(tag_o) != (c - 1) % 4 || int'(data_o) != (c - 1) % 4) begin
                    errors++;
                    $display("FAIL rr_head cycle %0d v_o=%b tag_o=%0d data_o=%0d required 1/%0d/%0d", c, v_o, tag_o, data_o, (c - 1) % 4, (c - 1) % 4);
                end
            end
            tick();
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic [W-1:0] p0;
        logic [W-1:0] p1;
        logic [N-1:0] exp_bp [6];
        logic         yreq_bp [6];
        exp_bp  = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
        yreq_bp = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        p0 = '0;
        p1 = '0;
        for (int c = 0; c < 6; c++) begin
            drive(4'h1, 4'h1, yreq_bp[c], 1'b1);
            settle();
            if (c == 0) p0 = pkt[0];
            if (c == 1) p1 = pkt[0];
            checks++;
            if (yumi_o !== exp_bp[c]) begin
                errors++;
                $display("FAIL bp_grant cycle %0d yumi_o=%b required %b", c, yumi_o, exp_bp[c]);
            end
            if (c == 1 || c == 2 || c == 3) begin
                checks++;
                if (v_o !== 1'b1 || data_o !== p0 || tag_o !== 2'd0) begin
                    errors++;
                    $display("FAIL bp_head_hold cycle %0d v_o=%b data_o=%h tag_o=%0d required 1/%h/0", c, v_o, data_o, tag_o, p0);
                end
            end
            if (c == 4) begin
                checks++;
                if (v_o !== 1'b1 || data_o !== p1) begin
                    errors++;
                    $display("FAIL bp_second_head v_o=%b data_o=%h required 1/%h", v_o, data_o, p1);
                end
            end
            tick();
        end
        drain();
    endtask

    task automatic test_wrap_skip();
        logic [N-1:0] exp_ws [3];
        exp_ws = '{4'b0001, 4'b0100, 4'b0001};
        drive(4'b0100, 4'b0100, 1'b1, 1'b1);
        settle();
        checks++;
        if (yumi_o !== 4'b0100) begin
            errors++;
            $display("FAIL ws_setup yumi_o=%b required 0100", yumi_o);
        end
        tick();
        for (int c = 0; c < 3; c++) begin
            drive(4'b0101, 4'b0101, 1'b1, 1'b1);
            settle();
            checks++;
            if (yumi_o !== exp_ws[c]) begin
                errors++;
                $display("FAIL ws_grant step %0d yumi_o=%b required %b", c, yumi_o, exp_ws[c]);
            end
            tick();
        end
        drain();
    endtask

    task automatic test_enable();
        for (int c = 0; c < 2; c++) begin
            drive(4'b0010, 4'b0010, 1'b0, 1'b1);
            settle();
            checks++;
            if (yumi_o !== 4'b0010) begin
                errors++;
                $display("FAIL en_fill cycle %0d yumi_o=%b required 0010", c, yumi_o);
            end
            tick();
        end
        for (int c = 0; c < 4; c++) begin
            drive(4'b1101, 4'b1111, 1'b1, 1'b1);
            settle();
            checks++;
            if (yumi_o[1] !== 1'b0 || yumi_o !== exp_yumi) begin
                errors++;
                $display("FAIL en_disabled cycle %0d yumi_o=%b required %b", c, yumi_o, exp_yumi);
            end
            if (c < 2) begin
                checks++;
                if (v_o !== 1'b1 || tag_o !== 2'd1) begin
                    errors++;
                    $display("FAIL en_drain cycle %0d v_o=%b tag_o=%0d required 1/1", c, v_o, tag_o);
                end
            end
            tick();
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] prev;
        drive(4'b1000, 4'b1000, 1'b0, 1'b1);
        settle();
        prev = pkt[3];
        checks++;
        if (yumi_o !== 4'b1000) begin
            errors++;
            $display("FAIL b2b_first yumi_o=%b required 1000", yumi_o);
        end
        tick();
        for (int c = 0; c < 10; c++) begin
            drive(4'b1000, 4'b1000, 1'b1, 1'b1);
            settle();
            checks++;
            if (yumi_o !== 4'b1000 || v_o !== 1'b1 || data_o !== prev || tag_o !== 2'd3) begin
                errors++;
                $display("FAIL b2b cycle %0d yumi_o=%b v_o=%b data_o=%h tag_o=%0d required 1000/1/%h/3", c, yumi_o, v_o, data_o, tag_o, prev);
            end
            prev = pkt[3];
            tick();
        end
        drive(4'h0, 4'h0, 1'b1, 1'b1);
        settle();
        checks++;
        if (v_o !== 1'b1 || data_o !== prev) begin
            errors++;
            $display("FAIL b2b_last v_o=%b data_o=%h required 1/%h", v_o, data_o, prev);
        end
        tick();
        drain();
        drive(4'h0, 4'h0, 1'b0, 1'b1);
        settle();
        checks++;
        if (v_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_empty v_o=%b required 0", v_o);
        end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive(N'($urandom), N'($urandom), ($urandom_range(0, 3) != 0), 1'b1);
            settle();
            checks++;
            if (yumi_o !== exp_yumi) begin
                errors++;
                $display("FAIL rand_grant cycle %0d yumi_o=%b required %b", c, yumi_o, exp_yumi);
            end
            checks++;
            if (v_o !== (q.size() != 0)) begin
                errors++;
                $display("FAIL rand_valid cycle %0d v_o=%b required %0d", c, v_o, q.size() != 0);
            end
            if (q.size() > 0) begin
                checks++;
                if (data_o !== q[0].data || tag_o !== q[0].tag) begin
                    errors++;
                    $display("FAIL rand_head cycle %0d data_o=%h tag_o=%0d required %h/%0d", c, data_o, tag_o, q[0].data, q[0].tag);
                end
            end
            tick();
        end
    endtask

    initial begin
        reset  = 1'b1;
        en     = '0;
        v      = '0;
        data   = '0;
        yumi_i = 1'b0;
        test_reset();
        test_round_robin();
        test_backpressure();
        test_wrap_skip();
        test_enable();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
